// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side bus between control logic and the program counter unit.
// The master drives the control inputs (write enable, select, offsets, stall/halt)
// and observes the PC outputs; the slave is the pc_unit itself.
interface pc_unit_if;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [15:0] immediate;
  logic [25:0] jaddr;
  logic        stall_req;
  logic        halt;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        fetch_valid;
  logic        halted;
  logic [31:0] instr_count;
  logic        pc_fault;

  modport master (
    output PCWre, PCSrc, immediate, jaddr, stall_req, halt,
    input  PC, PC4, fetch_valid, halted, instr_count, pc_fault
  );

  modport slave (
    input  PCWre, PCSrc, immediate, jaddr, stall_req, halt,
    output PC, PC4, fetch_valid, halted, instr_count, pc_fault
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential / branch / jump / hold selection,
// a RUN-STALL-HALT control FSM and an advance counter.
// Optional feature macro PC_RANGE_CHECK_EN: when defined, a next-PC whose last
// instruction byte falls outside the instruction memory is refused and the unit
// parks in a FAULT state (pc_fault=1) until reset. When undefined, no range check
// exists and pc_fault is tied low.
module pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 128
) (
  input  logic       CLK,
  input  logic       Reset,
  pc_unit_if.slave   bus
);

  // A memory smaller than one instruction word makes no sense.
  if (MEM_BYTES < 4) begin : g_bad_mem_bytes
    $error("pc_unit: MEM_BYTES must be at least 4");
  end

`ifdef PC_RANGE_CHECK_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] pc_target;
  logic        pc_advance;
  logic        out_of_range;

  // Candidate next-PC from the select; arithmetic wraps modulo 2^32.
  always_comb begin
    pc4        = pc_q + 32'd4;
    branch_off = {{14{bus.immediate[15]}}, bus.immediate, 2'b00};
    pc_target  = pc_q;
    unique case (bus.PCSrc)
      2'b00:   pc_target = pc4;
      2'b01:   pc_target = pc4 + branch_off;
      2'b10:   pc_target = {pc4[31:28], bus.jaddr, 2'b00};
      default: pc_target = pc_q;
    endcase
    // Select 11 rewrites PC with itself; it is not an advance.
    pc_advance = (bus.PCSrc != 2'b11);
  end

`ifdef PC_RANGE_CHECK_EN
  logic [32:0] target_last_byte;

  // Last byte of the fetched word must lie inside instruction memory.
  // Done in 33 bits so targets near 2^32 cannot wrap back into range.
  always_comb begin
    target_last_byte = {1'b0, pc_target} + 33'd3;
    out_of_range     = (target_last_byte > 33'(MEM_BYTES - 1));
  end
`else
  assign out_of_range = 1'b0;
`endif

  // Next-state, next-PC and next-count decisions for the control FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    unique case (state_q)
      ST_RUN: begin
        if (bus.halt) begin
          // halt wins over stall and suppresses this cycle's PC write
          state_d = ST_HALT;
        end else if (bus.stall_req) begin
          state_d = ST_STALL;
        end else if (bus.PCWre) begin
          if (out_of_range) begin
`ifdef PC_RANGE_CHECK_EN
            state_d = ST_FAULT;
`endif
          end else begin
            pc_d = pc_target;
            if (pc_advance) begin
              count_d = count_q + 32'd1;
            end
          end
        end
      end
      ST_STALL: begin
        // halt is deliberately ignored while stalled
        if (!bus.stall_req) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
`ifdef PC_RANGE_CHECK_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, PC and counter registers; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // Outputs are straight decodes of the registers.
  always_comb begin
    bus.PC          = pc_q;
    bus.PC4         = pc_q + 32'd4;
    bus.fetch_valid = (state_q == ST_RUN);
    bus.halted      = (state_q == ST_HALT);
    bus.instr_count = count_q;
`ifdef PC_RANGE_CHECK_EN
    bus.pc_fault    = (state_q == ST_FAULT);
`else
    bus.pc_fault    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios with fixed expected values plus a randomized run
// checked against a behavioural model of the program counter.
module tb_pc_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          MEM_BYTES = 128;

  localparam int M_RUN   = 0;
  localparam int M_STALL = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  // Behavioural model
  int unsigned m_pc;
  int unsigned m_cnt;
  int          m_mode;

  pc_unit_if bus ();

  pc_unit #(.RESET_PC(RESET_PC), .MEM_BYTES(MEM_BYTES)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs currently presented.
  task automatic model_step();
    int unsigned nxt;
    int          sx;
    bit          bad;
    if (rst) begin
      m_pc = RESET_PC; m_cnt = 0; m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (bus.halt) m_mode = M_HALT;
      else if (bus.stall_req) m_mode = M_STALL;
      else if (bus.PCWre) begin
        sx = $signed(bus.immediate);
        case (bus.PCSrc)
          2'd0: nxt = m_pc + 4;
          2'd1: nxt = m_pc + 4 + 32'(sx * 4);
          2'd2: nxt = ((m_pc + 4) & 32'hF000_0000) | (32'(bus.jaddr) * 4);
          default: nxt = m_pc;
        endcase
        bad = 1'b0;
`ifdef PC_RANGE_CHECK_EN
        bad = (longint'(nxt) + 3 > longint'(MEM_BYTES - 1));
`endif
        if (bad) m_mode = M_FAULT;
        else begin
          m_pc = nxt;
          if (bus.PCSrc != 2'd3) m_cnt = m_cnt + 1;
        end
      end
    end else if (m_mode == M_STALL) begin
      if (!bus.stall_req) m_mode = M_RUN;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit we, input bit [1:0] src, input bit [15:0] imm,
                       input bit [25:0] ja, input bit st, input bit hl);
    bus.PCWre = we; bus.PCSrc = src; bus.immediate = imm;
    bus.jaddr = ja; bus.stall_req = st; bus.halt = hl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, 16'd0, 26'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 2'd0, 16'd0, 26'd0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.PC !== RESET_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.PC, RESET_PC); end
    checks++; if (bus.PC4 !== RESET_PC + 32'd4) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", bus.PC4, RESET_PC + 32'd4); end
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL reset_fv got=%b exp=1", bus.fetch_valid); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.instr_count !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.instr_count); end
    checks++; if (bus.pc_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.pc_fault); end
    $display("reset: PC=%h", bus.PC);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'd4, 32'd8, 32'd12};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      advance(1);
      checks++; if (bus.PC !== exp_pc[i]) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.PC, exp_pc[i]); end
      $display("seq: PC=%h", bus.PC);
    end
    checks++; if (bus.instr_count !== 32'd3) begin errors++; $display("FAIL seq_cnt got=%0d exp=3", bus.instr_count); end
  endtask

  task automatic test_branch();
    do_reset(); advance(2);
    drive(1'b1, 2'd1, 16'hFFFE, 26'd0, 1'b0, 1'b0); tick();
    checks++; if (bus.PC !== 32'd4) begin errors++; $display("FAIL branch_back got=%h exp=4", bus.PC); end
    $display("branch: imm=FFFE PC=%h", bus.PC);
    do_reset(); advance(2);
    drive(1'b1, 2'd1, 16'h0003, 26'd0, 1'b0, 1'b0); tick();
    checks++; if (bus.PC !== 32'd24) begin errors++; $display("FAIL branch_fwd got=%h exp=18", bus.PC); end
    $display("branch: imm=0003 PC=%h", bus.PC);
  endtask

  task automatic test_jump();
    do_reset(); advance(4);
    drive(1'b1, 2'd2, 16'd0, 26'h000001F, 1'b0, 1'b0); tick();
    checks++; if (bus.PC !== 32'h0000_007C) begin errors++; $display("FAIL jump got=%h exp=0000007c", bus.PC); end
    checks++; if (bus.instr_count !== 32'd5) begin errors++; $display("FAIL jump_cnt got=%0d exp=5", bus.instr_count); end
    $display("jump: PC=%h", bus.PC);
  endtask

  task automatic test_stall();
    do_reset(); advance(3);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'd0, 16'd0, 26'd0, 1'b1, (i == 1)); tick();
      checks++; if (bus.PC !== 32'd12) begin errors++; $display("FAIL stall_pc%0d got=%h exp=c", i, bus.PC); end
      checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_fv%0d got=%b exp=0", i, bus.fetch_valid); end
      $display("stall: cycle=%0d PC=%h", i, bus.PC);
    end
    // halt seen while stalled is ignored
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL stall_halt got=%b exp=0", bus.halted); end
    drive(1'b1, 2'd0, 16'd0, 26'd0, 1'b0, 1'b0); tick();
    checks++; if (bus.fetch_valid !== 1'b1 || bus.PC !== 32'd12) begin errors++; $display("FAIL stall_exit got=%b/%h exp=1/c", bus.fetch_valid, bus.PC); end
    advance(1);
    checks++; if (bus.PC !== 32'd16) begin errors++; $display("FAIL stall_resume got=%h exp=10", bus.PC); end
    $display("stall: resume PC=%h", bus.PC);
  endtask

  task automatic test_halt();
    do_reset(); advance(5);
    drive(1'b1, 2'd0, 16'd0, 26'd0, 1'b1, 1'b1); tick();
    checks++; if (bus.halted !== 1'b1 || bus.PC !== 32'd20) begin errors++; $display("FAIL halt_enter got=%b/%h exp=1/14", bus.halted, bus.PC); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'($urandom_range(0, 2)), 16'($urandom), 26'($urandom), 1'($urandom), 1'($urandom)); tick();
      checks++; if (bus.PC !== 32'd20 || bus.instr_count !== 32'd5) begin errors++; $display("FAIL halt_hold%0d got=%h/%0d exp=14/5", i, bus.PC, bus.instr_count); end
    end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_fv got=%b exp=0", bus.fetch_valid); end
    do_reset();
    checks++; if (bus.PC !== 32'd0 || bus.halted !== 1'b0) begin errors++; $display("FAIL halt_reset got=%h/%b exp=0/0", bus.PC, bus.halted); end
    $display("halt: after reset PC=%h halted=%b", bus.PC, bus.halted);
  endtask

  task automatic test_range();
    do_reset();
    drive(1'b1, 2'd2, 16'd0, 26'h000001F, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd0, 16'd0, 26'd0, 1'b0, 1'b0); tick();
`ifdef PC_RANGE_CHECK_EN
    checks++; if (bus.PC !== 32'd124 || bus.pc_fault !== 1'b1 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL range got=%h/%b/%b exp=7c/1/0", bus.PC, bus.pc_fault, bus.fetch_valid); end
`else
    checks++; if (bus.PC !== 32'd128 || bus.pc_fault !== 1'b0) begin errors++; $display("FAIL range got=%h/%b exp=80/0", bus.PC, bus.pc_fault); end
`endif
    $display("range: PC=%h pc_fault=%b", bus.PC, bus.pc_fault);
    do_reset();
    checks++; if (bus.pc_fault !== 1'b0 || bus.PC !== 32'd0) begin errors++; $display("FAIL range_reset got=%b/%h exp=0/0", bus.pc_fault, bus.PC); end
  endtask

  task automatic test_back_to_back();
    do_reset(); advance(2);                                        // PC=8, cnt=2
    drive(1'b1, 2'd2, 16'd0, 26'd5, 1'b0, 1'b0); tick();          // -> 20
    drive(1'b1, 2'd1, 16'hFFFD, 26'd0, 1'b0, 1'b0); tick();       // 24-12 -> 12
    drive(1'b0, 2'd0, 16'd0, 26'd0, 1'b0, 1'b0); tick();          // hold 12
    drive(1'b1, 2'd3, 16'd0, 26'd0, 1'b0, 1'b0); tick();          // hold 12, no count
    checks++; if (bus.PC !== 32'd12) begin errors++; $display("FAIL b2b_pc got=%h exp=c", bus.PC); end
    checks++; if (bus.instr_count !== 32'd4) begin errors++; $display("FAIL b2b_cnt got=%0d exp=4", bus.instr_count); end
    $display("b2b: PC=%h cnt=%0d", bus.PC, bus.instr_count);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            16'($signed($urandom_range(0, 16)) - 8), 26'($urandom_range(0, 40)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0));
      tick();
      checks++;
      if (bus.PC !== m_pc || bus.PC4 !== m_pc + 32'd4 || bus.instr_count !== m_cnt ||
          bus.fetch_valid !== (m_mode == M_RUN) || bus.halted !== (m_mode == M_HALT) ||
          bus.pc_fault !== (m_mode == M_FAULT)) begin
        errors++;
        $display("FAIL rand%0d got pc=%h cnt=%0d fv=%b h=%b f=%b exp pc=%h cnt=%0d mode=%0d",
                 i, bus.PC, bus.instr_count, bus.fetch_valid, bus.halted, bus.pc_fault,
                 m_pc, m_cnt, m_mode);
      end
      $display("rand %0d: rst=%b PC=%h cnt=%0d", i, rst, bus.PC, bus.instr_count);
    end
    rst = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; rst = 1'b1;
    m_pc = RESET_PC; m_cnt = 0; m_mode = M_RUN;
    drive(1'b0, 2'd0, 16'd0, 26'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_halt();
    test_range();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address loaded into PC on reset.
REQ-002 Parameter MEM_BYTES, default 128, byte size of the instruction memory fed by PC.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 PCWre  input  1  PC write enable from control; 0 = hold PC this cycle.
REQ-006 PCSrc  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 hold.
REQ-007 immediate  input  16  branch offset in words, two's complement.
REQ-008 jaddr  input  26  jump target word address field.
REQ-009 stall_req  input  1  pipeline stall request from downstream.
REQ-010 halt  input  1  halt opcode decoded this cycle.
REQ-011 PC  output  32  current fetch byte address to instruction memory.
REQ-012 PC4  output  32  PC + 4, combinational from PC.
REQ-013 fetch_valid  output  1  high when PC addresses a valid instruction being fetched (state RUN).
REQ-014 halted  output  1  high in state HALT.
REQ-015 instr_count  output  32  number of PC advances since reset.
REQ-016 pc_fault  output  1  range fault flag (see Configuration).

Function
REQ-017 The block SHALL implement states RUN, STALL, HALT (plus FAULT when REQ-033 is compiled in).
REQ-018 RUN: if halt=1 -> HALT; else if stall_req=1 -> STALL; else PC updates per REQ-021 when PCWre=1.
REQ-019 STALL: PC and instr_count held; stall_req=0 -> RUN next cycle; halt is ignored in STALL.
REQ-020 HALT: terminal until Reset; PC, instr_count held; all inputs except Reset ignored.
REQ-021 Next PC: 00 -> PC4; 01 -> PC4 + {{14{immediate[15]}}, immediate, 2'b00}; 10 -> {PC4[31:28], jaddr, 2'b00}; 11 -> PC.
REQ-022 All next-PC arithmetic SHALL be 32-bit modulo 2^32; no carry out retained.
REQ-023 PC SHALL load on the cycle edge after the select is presented (latency 1); no update when PCWre=0.
REQ-024 instr_count SHALL increment by 1 on each edge where PC is written with PCSrc!=11 in RUN; wraps from 32'hFFFF_FFFF to 0.
REQ-025 Simultaneous halt and stall_req in RUN: halt wins, PC not updated that cycle.
REQ-026 halt in RUN SHALL suppress the PC update of that same cycle.
REQ-027 fetch_valid = (state==RUN); halted = (state==HALT).
REQ-028 PC[1:0] SHALL remain 2'b00 whenever RESET_PC[1:0]=00; no other alignment logic.

Reset
REQ-029 On Reset=1 at a rising edge: PC=RESET_PC, state=RUN, instr_count=0, pc_fault=0.
REQ-030 Reset SHALL override every other input in any state, including mid-stall, HALT and FAULT.
REQ-031 Outputs after reset: PC=RESET_PC, PC4=RESET_PC+4, fetch_valid=1, halted=0.
REQ-032 Reset deasserted: normal operation begins on the first following edge.

Configuration
REQ-033 Macro PC_RANGE_CHECK_EN, when defined: a next-PC value with value+3 > MEM_BYTES-1 SHALL not be loaded; state -> FAULT, pc_fault=1, fetch_valid=0, PC held, until Reset.
REQ-034 Without PC_RANGE_CHECK_EN: no range check, FAULT state absent, pc_fault tied 0, out-of-range values loaded as computed.

Verification
REQ-035 Reset, then 3 cycles PCWre=1 PCSrc=00 -> PC 0,4,8,12; instr_count=3.
REQ-036 PC=8, PCSrc=01 immediate=16'hFFFE -> PC=4 next cycle; immediate=16'h0003 from PC=8 -> PC=24.
REQ-037 PC=16, PCSrc=10 jaddr=26'h000001F -> PC=32'h0000_007C.
REQ-038 stall_req=1 for 2 cycles at PC=12 -> PC stays 12, fetch_valid=0 two cycles, then resumes at 16.
REQ-039 halt=1 with stall_req=1 at PC=20 -> halted=1, PC stays 20 through 5 further cycles; Reset -> PC=0, halted=0.
REQ-040 With PC_RANGE_CHECK_EN, PC=124 PCSrc=00 -> PC stays 124, pc_fault=1; without it -> PC=128, pc_fault=0.
